exec_ctrl_mem_unit: RTL and testbench

- Combined decode, execute and data-memory stage of the 8-bit single-cycle processor.
- Decodes one 8-bit instruction per cycle and generates all datapath controls.
- Selects and extends the immediate, muxes ALU operands, and runs the 8-bit ALU.
- Accesses a 256x8 data memory and produces register-file write-back data and branch/jump indications for the PC logic.

---
 rtl/exec_ctrl_mem_unit_pkg.sv | 31 +++
 rtl/exec_ctrl_mem_unit_alu8.sv | 28 ++
 rtl/exec_ctrl_mem_unit.sv | 92 +++++++++
 tb/tb_exec_ctrl_mem_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_mem_unit_pkg.sv
// Shared opcode, ALU-op and control-word definitions for the 8-bit decode/execute/memory stage.
// Pure definitions; no logic, no latency.
package exec_ctrl_mem_unit_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_J    = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       m;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/exec_ctrl_mem_unit_alu8.sv
// Combinational ALU: add/sub/and/or modulo 2**DATA_W plus zero flag.
// Zero latency, no flow control.
module exec_ctrl_mem_unit_alu8
    import exec_ctrl_mem_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/exec_ctrl_mem_unit.sv
// Single-cycle decode, ALU and 256x8 data memory; all outputs combinational from instr.
// Memory write on rising clk, blocked and array cleared while rst is high.
module exec_ctrl_mem_unit
    import exec_ctrl_mem_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_instr,
    input  logic              i_li,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    output logic              o_reg_write,
    output logic              o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [DATA_W-1:0] o_alu_out,
    output logic              o_zero,
    output logic              o_branch_taken,
    output logic              o_jump,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic [DATA_W-1:0] o_mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_out;
    logic              w_zero;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_comb begin
        w_ctrl = '0;
        case (i_instr[7:5])
            OP_ADD:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
            OP_SUB:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB};
            OP_AND:  w_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND};
            OP_LW:   w_ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD};
            OP_SW:   w_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
            OP_ADDI: w_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD};
            OP_BEQ:  w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_SUB};
            OP_J:    w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD};
            default: w_ctrl = '0;
        endcase
    end

    // ADDI takes a 4-bit unsigned field, BEQ a 3-bit unsigned offset, memory ops a signed 3-bit offset.
    always_comb begin
        if (w_ctrl.m)
            o_imm_ext = {{(DATA_W-4){1'b0}}, i_instr[3:0]};
        else if (w_ctrl.branch)
            o_imm_ext = {{(DATA_W-3){1'b0}}, i_instr[2:0]};
        else
            o_imm_ext = {{(DATA_W-3){i_instr[2]}}, i_instr[2:0]};
    end

    assign w_op_a = i_li ? '0 : i_rd1;
    assign w_op_b = w_ctrl.alu_src ? o_imm_ext : i_rd2;

    exec_ctrl_mem_unit_alu8 #(.DATA_W(DATA_W)) u_alu (
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .i_op     (w_ctrl.aluop),
        .o_result (w_alu_out),
        .o_zero   (w_zero)
    );

    assign w_addr = w_alu_out[ADDR_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_ctrl.mem_write) begin
            r_mem[w_addr] <= i_rd2;
        end
    end

    assign o_mem_rdata    = w_ctrl.mem_read ? r_mem[w_addr] : '0;
    assign o_alu_out      = w_alu_out;
    assign o_zero         = w_zero;
    assign o_reg_write    = w_ctrl.reg_write;
    assign o_wr_addr      = w_ctrl.m ? i_instr[4] : i_instr[3];
    assign o_wr_data      = w_ctrl.mem_to_reg ? o_mem_rdata : w_alu_out;
    assign o_branch_taken = w_ctrl.branch & w_zero;
    assign o_jump         = w_ctrl.jump;

endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
// Bench for exec_ctrl_mem_unit: directed vector table, memory/reset sequences, random vs. ISA-level model.
module tb_exec_ctrl_mem_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       li = 1'b0;
    logic [7:0] rd1 = 8'h00;
    logic [7:0] rd2 = 8'h00;
    logic       reg_write, wr_addr, zero, branch_taken, jump;
    logic [7:0] wr_data, alu_out, imm_ext, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [256];

    always #5 clk = ~clk;

    exec_ctrl_mem_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_instr        (instr),
        .i_li           (li),
        .i_rd1          (rd1),
        .i_rd2          (rd2),
        .o_reg_write    (reg_write),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_alu_out      (alu_out),
        .o_zero         (zero),
        .o_branch_taken (branch_taken),
        .o_jump         (jump),
        .o_imm_ext      (imm_ext),
        .o_mem_rdata    (mem_rdata)
    );

    // Packed observation: {reg_write, wr_addr, wr_data, alu_out, zero, branch_taken, jump, imm_ext, mem_rdata}
    function automatic logic [36:0] observed();
        return {reg_write, wr_addr, wr_data, alu_out, zero, branch_taken, jump, imm_ext, mem_rdata};
    endfunction

    // Instruction-level reference: what each opcode means, not how it is decoded.
    function automatic logic [36:0] model(input logic [7:0] ins, input logic l,
                                          input logic [7:0] a1, input logic [7:0] a2);
        logic [7:0] a, imm, res, rdat, wd;
        logic       we, wa, bt, j;
        a    = l ? 8'h00 : a1;
        imm  = {{5{ins[2]}}, ins[2:0]};
        rdat = 8'h00;
        we   = 1'b0;
        wa   = ins[3];
        bt   = 1'b0;
        j    = 1'b0;
        case (ins[7:5])
            3'd0: begin res = a + a2; we = 1'b1; end
            3'd1: begin res = a - a2; we = 1'b1; end
            3'd2: begin res = a & a2; we = 1'b1; end
            3'd3: begin res = a + imm; rdat = m_mem[res]; we = 1'b1; end
            3'd4: res = a + imm;
            3'd5: begin imm = {4'h0, ins[3:0]}; res = a + imm; we = 1'b1; wa = ins[4]; end
            3'd6: begin imm = {5'h00, ins[2:0]}; res = a - a2; bt = (res == 8'h00); end
            default: begin res = a + a2; j = 1'b1; end
        endcase
        wd = (ins[7:5] == 3'd3) ? rdat : res;
        return {we, wa, wd, res, (res == 8'h00), bt, j, imm, rdat};
    endfunction

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rw=%0b wa=%0b wd=%h alu=%h z=%0b bt=%0b j=%0b imm=%h rdat=%h, want rw=%0b wa=%0b wd=%h alu=%h z=%0b bt=%0b j=%0b imm=%h rdat=%h",
                     name, act[36], act[35], act[34:27], act[26:19], act[18], act[17], act[16], act[15:8], act[7:0],
                     exp[36], exp[35], exp[34:27], exp[26:19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    // Drive just after a rising edge; caller samples a few ns later, mid-cycle.
    task automatic apply(input logic [7:0] ins, input logic l, input logic [7:0] a1, input logic [7:0] a2);
        @(posedge clk);
        #1;
        instr = ins;
        li    = l;
        rd1   = a1;
        rd2   = a2;
        #3;
    endtask

    typedef struct {
        string      name;
        logic [7:0] ins;
        logic       l;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [36:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

        //                 name        instr         li    rd1    rd2      rw    wa    wd     alu    z     bt    j     imm    rdat
        vecs[0] = '{"reset_lw",  8'b011_0_0_000, 1'b0, 8'h20, 8'h00, {1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}};
        vecs[1] = '{"add",       8'b000_1_0_000, 1'b0, 8'd3,  8'd5,  {1'b1, 1'b0, 8'd8,  8'd8,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00}};
        vecs[2] = '{"sub_wrap",  8'b001_0_1_000, 1'b0, 8'd2,  8'd3,  {1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}};
        vecs[3] = '{"sub_zero",  8'b001_0_1_000, 1'b0, 8'd7,  8'd7,  {1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}};
        vecs[4] = '{"and",       8'b010_0_0_000, 1'b0, 8'hF0, 8'h3C, {1'b1, 1'b0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}};
        vecs[5] = '{"addi",      8'b101_1_1111,  1'b0, 8'd4,  8'h00, {1'b1, 1'b1, 8'd19, 8'd19, 1'b0, 1'b0, 1'b0, 8'd15, 8'h00}};
        vecs[6] = '{"li",        8'b101_1_1111,  1'b1, 8'd4,  8'h00, {1'b1, 1'b1, 8'd15, 8'd15, 1'b0, 1'b0, 1'b0, 8'd15, 8'h00}};
        vecs[7] = '{"beq_taken", 8'b110_0_1_101, 1'b0, 8'd9,  8'd9,  {1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd5,  8'h00}};
        vecs[8] = '{"beq_not",   8'b110_0_1_101, 1'b0, 8'd9,  8'd8,  {1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'd5,  8'h00}};
        vecs[9] = '{"jump",      8'b111_0_0_000, 1'b0, 8'd1,  8'd2,  {1'b0, 1'b0, 8'd3,  8'd3,  1'b0, 1'b0, 1'b1, 8'h00, 8'h00}};

        // Reset state: memory reads zero while rst is held.
        apply(vecs[0].ins, vecs[0].l, vecs[0].a1, vecs[0].a2);
        check(vecs[0].name, observed(), vecs[0].exp);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 1; i < 10; i++) begin
            apply(vecs[i].ins, vecs[i].l, vecs[i].a1, vecs[i].a2);
            check(vecs[i].name, observed(), vecs[i].exp);
        end

        // SW with offset -1 then LW of the same word.
        apply(8'b100_0_0_111, 1'b0, 8'h10, 8'hA5);
        check("sw_addr", observed(), {1'b0, 1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00});
        apply(8'b011_0_1_111, 1'b0, 8'h10, 8'h00);
        check("lw_back", observed(), {1'b1, 1'b1, 8'hA5, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hA5});

        // Read of the address being written returns old data until the edge.
        apply(8'b100_0_0_000, 1'b0, 8'h0F, 8'h5A);
        check("sw_same_addr", observed(), {1'b0, 1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        apply(8'b011_0_0_000, 1'b0, 8'h0F, 8'h00);
        check("lw_overwrite", observed(), {1'b1, 1'b0, 8'h5A, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A});

        // Reset sequence: store 3C at 0x20, then clear asynchronously mid-cycle.
        apply(8'b100_0_0_000, 1'b0, 8'h20, 8'h3C);
        apply(8'b011_0_0_000, 1'b0, 8'h20, 8'h00);
        check("lw_3c", observed(), {1'b1, 1'b0, 8'h3C, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C});
        #2 rst = 1'b1;
        #1;
        check("async_clear", observed(), {1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        apply(8'b100_0_0_000, 1'b0, 8'h20, 8'h77);
        apply(8'b011_0_0_000, 1'b0, 8'h20, 8'h00);
        #1 rst = 1'b0;
        #1;
        check("sw_in_reset", observed(), {1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        apply(8'b011_0_1_111, 1'b0, 8'h10, 8'h00);
        check("cleared_0f", observed(), {1'b1, 1'b1, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00});

        // Random programs; model memory starts cleared after the reset above.
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ins, a1, a2, addr;
            logic       l;
            ins = 8'($urandom);
            l   = ($urandom_range(0, 7) == 0);
            a1  = 8'($urandom_range(0, 15)) + 8'h20;
            a2  = 8'($urandom);
            apply(ins, l, a1, a2);
            check("random", observed(), model(ins, l, a1, a2));
            if (ins[7:5] == 3'd4) begin
                addr = (l ? 8'h00 : a1) + {{5{ins[2]}}, ins[2:0]};
                m_mem[addr] = a2;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary, required completion");
        $fatal(1);
    end

endmodule
